// File: rtl/hnoc_pkg.sv
// rtl/hnoc_pkg.sv - shared HNoC flit constants, flit struct and address helper
package hnoc_pkg;

  localparam int HNOC_FLIT_W = 35;
  localparam int HNOC_ADDR_W = 3;

  // Destination PE address rides in the top bits, payload below it
  typedef struct packed {
    logic [HNOC_ADDR_W-1:0]             addr;
    logic [HNOC_FLIT_W-HNOC_ADDR_W-1:0] payload;
  } hnoc_flit_t;

  function automatic logic [HNOC_ADDR_W-1:0] hnoc_addr(input logic [HNOC_FLIT_W-1:0] flit);
    return flit[HNOC_FLIT_W-1 -: HNOC_ADDR_W];
  endfunction

endpackage

// File: rtl/hnoc_rr_arbiter.sv
// rtl/hnoc_rr_arbiter.sv - combinational round-robin arbiter, one-hot grant plus encoded index
module hnoc_rr_arbiter
  import hnoc_pkg::*;
#(
  parameter int NumIn = 4,
  parameter int IdxW  = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic [NumIn-1:0] req,
  input  logic [IdxW-1:0]  ptr,
  output logic [NumIn-1:0] grant,
  output logic [IdxW-1:0]  grant_idx
);

  logic found;
  int   j;

  // Scan upward from ptr with wraparound; the first requester wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int i = 0; i < NumIn; i++) begin
      j = (int'(ptr) + i) % NumIn;
      if (!found && req[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/hnoc_port_arbiter.sv
// rtl/hnoc_port_arbiter.sv - round-robin output-link arbiter with 2-entry buffer; HNOC_ARB_STATS_EN adds grant counters
module hnoc_port_arbiter
  import hnoc_pkg::*;
#(
  parameter int FlitWidth = HNOC_FLIT_W,
  parameter int AddrWidth = HNOC_ADDR_W,
  parameter int NumIn     = 4,
  parameter int DestMin   = 0,
  parameter int DestMax   = 3
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [NumIn*FlitWidth-1:0] i_in_data,
  input  logic [NumIn-1:0]           i_in_data_valid,
  output logic [NumIn-1:0]           o_in_data_ready,
  output logic [FlitWidth-1:0]       o_out_data,
  output logic                       o_out_data_valid,
  input  logic                       i_out_data_ready
`ifdef HNOC_ARB_STATS_EN
  ,
  output logic [NumIn*16-1:0]        o_grant_count
`endif
);

  localparam int IdxW = (NumIn > 1) ? $clog2(NumIn) : 1;

  logic [FlitWidth-1:0] in_flit [NumIn];
  logic [AddrWidth-1:0] in_addr [NumIn];
  logic [NumIn-1:0]     req;
  logic [NumIn-1:0]     grant;
  logic [IdxW-1:0]      grant_idx;
  logic [IdxW-1:0]      ptr;
  logic [1:0]           count;
  logic [FlitWidth-1:0] head;
  logic [FlitWidth-1:0] tail;
  logic [FlitWidth-1:0] push_data;
  logic                 space;
  logic                 push;
  logic                 pop;

  for (genvar k = 0; k < NumIn; k++) begin : g_in
    assign in_flit[k] = i_in_data[k*FlitWidth +: FlitWidth];
    assign in_addr[k] = in_flit[k][FlitWidth-1 -: AddrWidth];
    // Only flits headed to a PE behind this output compete for it
    assign req[k]     = i_in_data_valid[k]
                        && (int'(in_addr[k]) >= DestMin)
                        && (int'(in_addr[k]) <= DestMax);
  end

  hnoc_rr_arbiter #(
    .NumIn (NumIn),
    .IdxW  (IdxW)
  ) u_rr (
    .req       (req),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Space comes from registered count only, so downstream ready never reaches upstream ready
  assign space            = (count < 2'd2);
  assign o_in_data_ready  = (space && !i_reset) ? grant : '0;
  assign push             = |o_in_data_ready;
  assign pop              = o_out_data_valid && i_out_data_ready;
  assign push_data        = in_flit[grant_idx];
  assign o_out_data_valid = (count != 2'd0);
  assign o_out_data       = head;

  // Two-entry FIFO with the head held in its own register, plus rr pointer advance on push
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
      ptr   <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= push_data;
          else               tail <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Push only happens below full, so with a pop the single entry is replaced
          if (count == 2'd1) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: ;
      endcase
      if (push) begin
        ptr <= (grant_idx == IdxW'(NumIn - 1)) ? '0 : grant_idx + IdxW'(1);
      end
    end
  end

`ifdef HNOC_ARB_STATS_EN
  logic [15:0] grant_count [NumIn];

  // Per-input saturating push counters
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < NumIn; k++) begin
      if (i_reset) begin
        grant_count[k] <= 16'h0000;
      end else if (o_in_data_ready[k] && grant_count[k] != 16'hFFFF) begin
        grant_count[k] <= grant_count[k] + 16'h0001;
      end
    end
  end

  for (genvar k = 0; k < NumIn; k++) begin : g_cnt
    assign o_grant_count[k*16 +: 16] = grant_count[k];
  end
`endif

endmodule

// File: tb/tb_hnoc_port_arbiter.sv
// tb/tb_hnoc_port_arbiter.sv - directed self-checking bench for hnoc_port_arbiter
module tb_hnoc_port_arbiter;
  import hnoc_pkg::*;

  logic         clk;
  logic         rst;
  logic [34:0]  fl [4];
  logic [139:0] in_data;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [34:0]  out_data;
  logic         out_valid;
  logic         out_ready;
`ifdef HNOC_ARB_STATS_EN
  logic [63:0]  grant_count;
`endif

  int checks = 0;
  int errors = 0;

  assign in_data = {fl[3], fl[2], fl[1], fl[0]};

  hnoc_port_arbiter dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_in_data        (in_data),
    .i_in_data_valid  (in_valid),
    .o_in_data_ready  (in_ready),
    .o_out_data       (out_data),
    .o_out_data_valid (out_valid),
    .i_out_data_ready (out_ready)
`ifdef HNOC_ARB_STATS_EN
    ,
    .o_grant_count    (grant_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [34:0] mkflit(input logic [2:0] a, input logic [31:0] p);
    hnoc_flit_t f;
    f.addr    = a;
    f.payload = p;
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic       took;
  logic [3:0] exp_rdy;
  int         n;

  initial begin
    rst       = 1'b1;
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) fl[k] = '0;
    #1;

    // Reset held 3 cycles with every input requesting addr 1
    for (int k = 0; k < 4; k++) fl[k] = mkflit(3'd1, 32'hB0 + k);
    in_valid = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("rst_valid", out_valid, 1'b0);
      check_eq("rst_ready", in_ready, 4'b0000);
      tick();
    end
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_first_grant", in_ready, 4'b0001);
    tick();
    @(negedge clk);
    check_eq("rst_first_valid", out_valid, 1'b1);
    check_eq("rst_first_data", out_data, mkflit(3'd1, 32'hB0));

    // Round-robin over four eligible inputs, one flit per cycle
    in_valid = 4'b0000;
    do_reset();
    for (int k = 0; k < 4; k++) fl[k] = mkflit(3'(k), 32'hA0 + k);
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      exp_rdy = 4'b0001 << (c % 4);
      check_eq("rr_ready", in_ready, exp_rdy);
      if (c > 0) begin
        check_eq("rr_valid", out_valid, 1'b1);
        check_eq("rr_data", out_data, mkflit(3'((c - 1) % 4), 32'hA0 + ((c - 1) % 4)));
        check_eq("rr_addr", hnoc_addr(out_data), 3'((c - 1) % 4));
      end
      tick();
    end

    // Range filter: input 2 targets addr 5, outside [0,3]
    in_valid = 4'b0000;
    do_reset();
    fl[0] = mkflit(3'd2, 32'hC0);
    fl[1] = mkflit(3'd2, 32'hC1);
    fl[2] = mkflit(3'd5, 32'hC2);
    in_valid = 4'b0111;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_eq("rf_ready", in_ready, (c % 2 == 0) ? 4'b0001 : 4'b0010);
      if (c > 0) check_eq("rf_data", out_data, mkflit(3'd2, (c % 2 == 1) ? 32'hC0 : 32'hC1));
      tick();
    end

    // Backpressure: input 1 streams while downstream stalls 5 cycles
    in_valid = 4'b0000;
    do_reset();
    n         = 0;
    fl[1]     = mkflit(3'd0, 32'h100);
    in_valid  = 4'b0010;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_eq("bp_ready", in_ready, (c < 2) ? 4'b0010 : 4'b0000);
      if (c > 0) begin
        check_eq("bp_valid", out_valid, 1'b1);
        check_eq("bp_stable", out_data, mkflit(3'd0, 32'h100));
      end
      took = in_ready[1];
      tick();
      if (took) begin
        n++;
        fl[1] = mkflit(3'd0, 32'h100 + n);
      end
    end
    check_eq("bp_accepted", 32'(n), 32'd2);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("bp_rel_valid", out_valid, 1'b1);
      check_eq("bp_rel_data", out_data, mkflit(3'd0, 32'h100 + c));
      check_eq("bp_rel_ready", in_ready, (c == 0) ? 4'b0000 : 4'b0010);
      took = in_ready[1];
      tick();
      if (took) begin
        n++;
        fl[1] = mkflit(3'd0, 32'h100 + n);
      end
    end

    // Mid-operation reset with a full buffer and ptr moved off 0
    in_valid = 4'b0000;
    do_reset();
    for (int k = 0; k < 4; k++) fl[k] = mkflit(3'(k), 32'hD0 + k);
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check_eq("mr_full_ready", in_ready, 4'b0000);
    check_eq("mr_full_data", out_data, mkflit(3'd0, 32'hD0));
    rst = 1'b1;
    @(negedge clk);
    check_eq("mr_rst_ready", in_ready, 4'b0000);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("mr_valid", out_valid, 1'b0);
    check_eq("mr_data", out_data, 35'd0);
    check_eq("mr_ptr", in_ready, 4'b0001);
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    check_eq("mr_after_data", out_data, mkflit(3'd0, 32'hD0));

`ifdef HNOC_ARB_STATS_EN
    // Saturating grant counters
    in_valid = 4'b0000;
    do_reset();
    @(negedge clk);
    check_eq("st_reset", grant_count, 64'd0);
    tick();
    in_valid  = 4'b0001;
    out_ready = 1'b1;
    repeat (5) tick();
    in_valid = 4'b1000;
    repeat (70000) tick();
    in_valid = 4'b0000;
    @(negedge clk);
    check_eq("st_cnt0", grant_count[15:0], 16'd5);
    check_eq("st_cnt1", grant_count[31:16], 16'd0);
    check_eq("st_cnt2", grant_count[47:32], 16'd0);
    check_eq("st_cnt3", grant_count[63:48], 16'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hnoc_port_arbiter.md
Name: hnoc_port_arbiter

Overview:
- Round-robin arbiter plus 2-entry output buffer that shares one HNoC switch output link between NumIn input ports.
- Each input flit carries its destination PE address in its top AddrWidth bits.
- Only inputs whose destination falls inside [DestMin, DestMax] compete for this output.
- Used per output direction inside a leaf/centre switch, e.g. the centre uplink between leaves or a PE downlink.

Parameters:
- FlitWidth, 35, total flit width (payload + address), the same value passed as DataWidth to HLeaf.
- AddrWidth, 3, destination address width; address = flit[FlitWidth-1 -: AddrWidth].
- NumIn, 4, number of competing input ports (2..8).
- DestMin, 0, lowest destination address routed to this output.
- DestMax, 3, highest destination address routed to this output.

Ports:
- i_clk, input, 1, the single clock.
- i_reset, input, 1, synchronous, active-high reset.
- i_in_data, input, NumIn*FlitWidth, flattened input flits; port k = bits [k*FlitWidth +: FlitWidth].
- i_in_data_valid, input, NumIn, per-input valid.
- o_in_data_ready, output, NumIn, per-input ready; asserted only for the granted input.
- o_out_data, output, FlitWidth, head flit of the output buffer.
- o_out_data_valid, output, 1, output buffer non-empty.
- i_out_data_ready, input, 1, downstream ready.

Behaviour:
- Interface (already decided): one clock, i_clk; reset i_reset is synchronous and active-high.
- Reset (i_reset high at posedge): buffer count=0, o_out_data_valid=0, o_out_data=0, rr pointer=0, stats counters=0. Reset mid-operation discards any buffered flits. o_in_data_ready is 0 while i_reset is high.
- Eligibility: req[k] = i_in_data_valid[k] && DestMin <= addr_k <= DestMax (unsigned compare).
  - Out-of-range inputs are never granted; their ready stays 0.
- Grant: combinational. Search req from index ptr upward, wrapping mod NumIn; the first set bit wins. One-hot, or zero if there is no request.
- space = (count < 2). Depends on registered state only; there is no combinational path from i_out_data_ready to o_in_data_ready.
- o_in_data_ready[k] = grant[k] && space && !i_reset. This ready depends combinationally on i_in_data_valid; the upstream side must not make valid depend on ready.
- Push occurs when the granted input's valid && ready; the flit is written to the buffer tail.
- Pop occurs when o_out_data_valid && i_out_data_ready.
- Buffer: 2-entry FIFO with registered head.
  - Push+pop in the same cycle: count unchanged, order preserved.
  - Push into empty: flit visible on o_out_data the next cycle. Latency = 1 cycle.
  - Full (count=2): no grants are acknowledged. A pop that cycle frees space the following cycle.
- Throughput: 1 flit/cycle sustained while downstream holds ready=1.
- Pointer update: only on push; ptr <= (granted index + 1) mod NumIn. ptr holds when there is no push.
- Fairness: a continuously eligible input is served within NumIn pushes.
- Flit contents pass unmodified. o_out_data is stable while o_out_data_valid=1 and i_out_data_ready=0.
- Single-flit packets only; no wormhole lock.

Optional Feature:
- Macro: HNOC_ARB_STATS_EN.
- When defined, adds output o_grant_count of width NumIn*16: one saturating 16-bit counter per input.
  - Counter increments on each push from that input and holds at 16'hFFFF.
  - Cleared by i_reset.
- When undefined, the port and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package hnoc_pkg:
  - HNOC_FLIT_W and HNOC_ADDR_W constants.
  - Address-extract function.
  - Flit struct typedef {addr, payload}.
- Sub-module: hnoc_rr_arbiter (req, ptr -> one-hot grant plus encoded index), purely combinational, reusable by other switch outputs.
- The FIFO stays inline in hnoc_port_arbiter.

Test Plan:
- Reset: hold i_reset 3 cycles with all inputs valid and addr=1 -> o_out_data_valid=0, o_in_data_ready=0 throughout; first grant goes to input 0 on the cycle after reset deasserts.
- Round-robin: all 4 inputs valid with addr 0..3 and payloads 0xA0..0xA3, i_out_data_ready=1 -> output order A0, A1, A2, A3, A0..., one flit/cycle, 1-cycle latency.
- Range filter: DestMin=0, DestMax=3; input 2 has addr=5 and inputs 0, 1 have addr=2 -> input 2 ready never asserts; only inputs 0 and 1 alternate.
- Backpressure: i_out_data_ready=0 for 5 cycles with input 1 streaming -> exactly 2 flits accepted, o_out_data stable; on release, the flits emerge in order with no loss or duplication.
- Mid-operation reset: count=2, assert i_reset for 1 cycle -> next cycle o_out_data_valid=0, ptr=0, buffered flits gone.
- Stats (HNOC_ARB_STATS_EN): 70000 pushes from input 3 -> o_grant_count[3*16 +: 16] = 16'hFFFF; other counters reflect their exact push counts.
